keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_tick_gen.sv | 27 ++
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_e;

    localparam logic [3:0] ROW_IDLE = 4'b1110;
    localparam logic [3:0] COL_NONE = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } col_dec_t;

    // Exactly one low column is a usable key; idle or multi-key patterns are not.
    function automatic col_dec_t onehot_low_idx(input logic [3:0] pat);
        col_dec_t dec;
        dec = '{valid: 1'b0, idx: 2'd0};
        case (pat)
            4'b1110: dec = '{valid: 1'b1, idx: 2'd0};
            4'b1101: dec = '{valid: 1'b1, idx: 2'd1};
            4'b1011: dec = '{valid: 1'b1, idx: 2'd2};
            4'b0111: dec = '{valid: 1'b1, idx: 2'd3};
            default: dec = '{valid: 1'b0, idx: 2'd0};
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Clock divider producing a one-clock scan tick every DIV clocks.
module keypad_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, debounce and key reporting.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays pressed.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS);

    if (DIV < 2) begin : g_bad_div
        $error("keypad_scanner: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_counts
        $error("keypad_scanner: debounce and repeat counts must be at least 1");
    end

    state_e           r_state, w_state_nxt;
    logic [1:0]       r_row_idx, w_row_idx_nxt;
    logic [1:0]       r_col_idx, w_col_idx_nxt;
    logic [DEB_W-1:0] r_deb_cnt, w_deb_cnt_nxt, w_deb_inc;
    logic [3:0]       r_key_code, w_key_code_nxt;
    logic             r_key_valid, w_key_valid_nxt;
    logic             r_key_held, w_key_held_nxt;
    logic [3:0]       r_col_s1, r_col_s2;
    logic [7:0]       w_row_rot;
    logic             w_tick, w_accept, w_release_done;
    col_dec_t         w_dec;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt, w_rep_inc;
    logic             r_rep_first, w_rep_first_nxt;
    assign w_rep_inc = r_rep_cnt + REP_W'(1);
`endif

    keypad_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk   (clk),
        .i_reset (reset),
        .o_tick  (w_tick)
    );

    assign w_dec     = onehot_low_idx(r_col_s2);
    assign w_deb_inc = r_deb_cnt + DEB_W'(1);
    assign w_row_rot = {ROW_IDLE, ROW_IDLE} << r_row_idx;
    assign row_out   = w_row_rot[7:4];
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

    always_comb begin
        w_state_nxt     = r_state;
        w_row_idx_nxt   = r_row_idx;
        w_col_idx_nxt   = r_col_idx;
        w_deb_cnt_nxt   = r_deb_cnt;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;
        w_accept        = 1'b0;
        w_release_done  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_first_nxt = r_rep_first;
`endif
        if (w_tick) begin
            unique case (r_state)
                SCAN: begin
                    if (w_dec.valid) begin
                        w_col_idx_nxt = w_dec.idx;
                        w_deb_cnt_nxt = DEB_W'(1);
                        if (DEBOUNCE_SCANS == 1) w_accept = 1'b1;
                        else                     w_state_nxt = DEBOUNCE;
                    end else begin
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_dec.valid && w_dec.idx == r_col_idx) begin
                        w_deb_cnt_nxt = w_deb_inc;
                        if (w_deb_inc == DEB_LAST) w_accept = 1'b1;
                    end else begin
                        w_state_nxt   = SCAN;
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end
                PRESSED: begin
                    if (r_col_s2 == COL_NONE) begin
                        w_deb_cnt_nxt = DEB_W'(1);
                        if (DEBOUNCE_SCANS == 1) w_release_done = 1'b1;
                        else                     w_state_nxt = RELEASE;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (w_rep_inc == (r_rep_first ? REP_W'(REPEAT_DELAY)
                                                      : REP_W'(REPEAT_RATE))) begin
                            w_key_valid_nxt = 1'b1;
                            w_rep_cnt_nxt   = '0;
                            w_rep_first_nxt = 1'b0;
                        end else begin
                            w_rep_cnt_nxt   = w_rep_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    // Any low column is treated as release bounce, not a new press.
                    if (r_col_s2 == COL_NONE) begin
                        w_deb_cnt_nxt = w_deb_inc;
                        if (w_deb_inc == DEB_LAST) w_release_done = 1'b1;
                    end else begin
                        w_state_nxt = PRESSED;
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end
        if (w_accept) begin
            w_state_nxt     = PRESSED;
            w_key_code_nxt  = {r_row_idx, w_col_idx_nxt};
            w_key_valid_nxt = 1'b1;
            w_key_held_nxt  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b1;
`endif
        end
        if (w_release_done) begin
            w_state_nxt    = SCAN;
            w_key_held_nxt = 1'b0;
            w_row_idx_nxt  = r_row_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SCAN;
            r_row_idx   <= 2'd0;
            r_col_idx   <= 2'd0;
            r_deb_cnt   <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_col_s1    <= COL_NONE;
            r_col_s2    <= COL_NONE;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
            r_col_s1    <= col_in;
            r_col_s2    <= r_col_s1;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_first <= w_rep_first_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a physical keypad and a tick-level reference model.
module tb_keypad_scanner;

    localparam int unsigned CLK_HZ  = 16;
    localparam int unsigned SCAN_HZ = 4;
    localparam int unsigned DEB     = 3;
    localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;

    localparam int MD_SCAN = 0;
    localparam int MD_DEB  = 1;
    localparam int MD_PRS  = 2;
    localparam int MD_REL  = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_pulses = 0;

    // Reference model state
    int         m_mode, m_row, m_col, m_cnt, m_code, m_clk;
    bit         m_valid, m_held;
    logic [3:0] m_s1, m_s2;

    always #5 clk = ~clk;

    keypad_scanner #(
        .CLK_HZ         (CLK_HZ),
        .SCAN_HZ        (SCAN_HZ),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_DELAY   (5),
        .REPEAT_RATE    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Physical keypad: key r*4+c shorts row r to column c.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MD_SCAN; m_row = 0; m_col = 0; m_cnt = 0; m_code = 0; m_clk = 0;
        m_valid = 1'b0; m_held = 1'b0; m_s1 = 4'hF; m_s2 = 4'hF;
    endtask

    task automatic model_accept();
        m_mode = MD_PRS; m_code = m_row * 4 + m_col; m_valid = 1'b1; m_held = 1'b1;
    endtask

    task automatic model_release_done();
        m_mode = MD_SCAN; m_held = 1'b0; m_row = (m_row + 1) % 4;
    endtask

    // Advance the model by one clock, given the col_in value present before the edge.
    task automatic model_step(input logic [3:0] smp);
        logic [3:0] cs;
        bit tick;
        int zeros, col;
        cs = m_s2; m_s2 = m_s1; m_s1 = smp;
        tick = ((m_clk % DIV) == DIV - 1);
        m_clk++;
        m_valid = 1'b0;
        if (tick) begin
            zeros = 0; col = 0;
            for (int c = 0; c < 4; c++) if (!cs[c]) begin zeros++; col = c; end
            case (m_mode)
                MD_SCAN: if (zeros == 1) begin
                    m_col = col; m_cnt = 1;
                    if (DEB == 1) model_accept(); else m_mode = MD_DEB;
                end else m_row = (m_row + 1) % 4;
                MD_DEB: if (zeros == 1 && col == m_col) begin
                    m_cnt++;
                    if (m_cnt == DEB) model_accept();
                end else begin
                    m_mode = MD_SCAN; m_row = (m_row + 1) % 4;
                end
                MD_PRS: if (zeros == 0) begin
                    m_cnt = 1;
                    if (DEB == 1) model_release_done(); else m_mode = MD_REL;
                end
                default: if (zeros == 0) begin
                    m_cnt++;
                    if (m_cnt == DEB) model_release_done();
                end else m_mode = MD_PRS;
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [3:0] exp_row;
        exp_row = 4'hF;
        exp_row[m_row] = 1'b0;
        check_eq("row_out", row_out, exp_row);
        check_eq("key_code", key_code, m_code);
        check_eq("key_valid", key_valid, m_valid);
        check_eq("key_held", key_held, m_held);
    endtask

    // Called at a falling edge; runs one clock with the given key mask.
    task automatic cycle(input logic [15:0] k);
        keys = k;
        #1;
        model_step(col_in);
        @(negedge clk);
        if (key_valid) dut_pulses++;
        check_outputs();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        keys  = 16'h0000;
        #1;
        check_eq("rst_row_out", row_out, 4'b1110);
        check_eq("rst_key_code", key_code, 4'h0);
        check_eq("rst_key_valid", key_valid, 1'b0);
        check_eq("rst_key_held", key_held, 1'b0);
        @(negedge clk);
        check_eq("rst_hold_valid", key_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] k;
        int kind, dur;
        bit reached;

        @(negedge clk);
        apply_reset();

        // Idle scanning: rows rotate every DIV clocks
        repeat (24) cycle(16'h0000);

        // Clean press of row 2, col 1
        dut_pulses = 0;
        repeat (60) cycle(16'h0200);
        check_eq("press_held", key_held, 1'b1);
        check_eq("press_row", row_out, 4'b1011);
        check_eq("press_code", key_code, 4'b1001);
        repeat (40) cycle(16'h0000);
        check_eq("press_pulses", dut_pulses, 1);
        check_eq("release_held", key_held, 1'b0);
        check_eq("retain_code", key_code, 4'b1001);

        // Press bounce: a short contact then a gap before the stable press
        dut_pulses = 0;
        repeat (4)  cycle(16'h0200);
        repeat (4)  cycle(16'h0000);
        repeat (60) cycle(16'h0200);
        repeat (40) cycle(16'h0000);
        check_eq("bounce_pulses", dut_pulses, 1);

        // Release bounce: one tick released, then pressed again
        dut_pulses = 0;
        repeat (60) cycle(16'h0040);
        repeat (4)  cycle(16'h0000);
        repeat (20) cycle(16'h0040);
        check_eq("relbounce_held", key_held, 1'b1);
        repeat (40) cycle(16'h0000);
        check_eq("relbounce_pulses", dut_pulses, 1);
        check_eq("relbounce_code", key_code, 4'b0110);

        // Two keys on row 0 are ignored
        dut_pulses = 0;
        repeat (60) cycle(16'h0003);
        repeat (20) cycle(16'h0000);
        check_eq("multikey_pulses", dut_pulses, 0);

        // Reset while debouncing
        dut_pulses = 0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            cycle(16'h0200);
            if (m_mode == MD_DEB) reached = 1'b1;
        end
        check_eq("reach_debounce", reached, 1'b1);
        apply_reset();
        repeat (20) cycle(16'h0000);
        check_eq("midreset_pulses", dut_pulses, 0);

        // Randomized key activity with occasional bounce
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 3);
            k = 16'h0000;
            if (kind >= 1) k[$urandom_range(0, 15)] = 1'b1;
            if (kind == 3) k[$urandom_range(0, 15)] = 1'b1;
            dur = $urandom_range(1, 30);
            for (int j = 0; j < dur; j++) begin
                if ($urandom_range(0, 7) == 0) cycle(16'h0000);
                else                           cycle(k);
            end
        end
        repeat (40) cycle(16'h0000);
        check_eq("final_held", key_held, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
